a_codec_i2s: RTL and testbench

Parametrised I2S master for the board audio codec: generates XCK/BCK/LRCK from the single system clock, serialises a stereo frame accepted over a valid/ready handshake, and (optionally) deserialises the ADC stream into stereo samples with a hysteretic 1-bit tape detector. It replaces the fixed 16-bit, free-running codec interface between the sound mixer and the codec pins.

---
 rtl/a_codec_i2s.sv | 213 +++++++++++++++++++++
 tb/tb_a_codec_i2s.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_codec_i2s.sv
// a_codec_i2s: I2S master for the board codec. Derives XCK/BCK/LRCK from iCLK, serialises stereo frames
// taken over valid/ready, and with A_CODEC_ADC_EN defined also receives the ADC stream and drives a tape bit.
module a_codec_i2s #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_WIDTH = 18,
   parameter int BCK_HALF   = 4,
   parameter int HYST       = 3
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic [DATA_WIDTH-1:0] iSL,
   input  logic [DATA_WIDTH-1:0] iSR,
   input  logic                  iVALID,
   output logic                  oREADY,
   output logic                  oUNDERRUN,
   output logic                  oAUD_XCK,
   output logic                  oAUD_BCK,
   output logic                  oAUD_LRCK,
   output logic                  oAUD_DATA,
   output logic                  oAUD_ADCLRCK,
   input  logic                  iAUD_ADCDAT,
   output logic [DATA_WIDTH-1:0] oADC_L,
   output logic [DATA_WIDTH-1:0] oADC_R,
   output logic                  oADC_VALID,
   output logic                  oTAPE
);

   localparam int CW = $clog2(BCK_HALF);
   localparam int SW = $clog2(SLOT_WIDTH);
   localparam logic [CW-1:0] BCK_LAST  = CW'(BCK_HALF - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_WIDTH - 1);
   localparam logic [SW-1:0] DW_S      = SW'(DATA_WIDTH);

   logic                  r_xck;
   logic                  r_bck;
   logic [CW-1:0]         r_bck_cnt;
   logic                  r_lrck;
   logic [SW-1:0]         r_slot;
   logic                  r_data;
   logic [DATA_WIDTH-1:0] r_tx_sh;
   logic                  r_hold_full;
   logic [DATA_WIDTH-1:0] r_hold_l;
   logic [DATA_WIDTH-1:0] r_hold_r;
   logic [DATA_WIDTH-1:0] r_frame_l;
   logic [DATA_WIDTH-1:0] r_frame_r;
   logic                  r_underrun;

   logic                  w_bck_wrap;
   logic                  w_fall;
   logic                  w_slot_wrap;
   logic [SW-1:0]         w_slot_nxt;
   logic                  w_frame_start;
   logic                  w_accept;
   logic                  w_bit_active;
   logic [DATA_WIDTH-1:0] w_frame_l_nxt;

   assign w_bck_wrap    = (r_bck_cnt == BCK_LAST);
   assign w_fall        = w_bck_wrap & r_bck;
   assign w_slot_wrap   = (r_slot == SLOT_LAST);
   assign w_slot_nxt    = w_slot_wrap ? '0 : r_slot + 1'b1;
   assign w_frame_start = w_fall & w_slot_wrap & r_lrck;
   assign w_accept      = iVALID & ~r_hold_full;
   assign w_bit_active  = (w_slot_nxt != '0) && (w_slot_nxt <= DW_S);
   assign w_frame_l_nxt = r_hold_full ? r_hold_l : r_frame_l;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_xck     <= 1'b0;
         r_bck     <= 1'b0;
         r_bck_cnt <= '0;
      end else begin
         r_xck <= ~r_xck;
         if (w_bck_wrap) begin
            r_bck_cnt <= '0;
            r_bck     <= ~r_bck;
         end else begin
            r_bck_cnt <= r_bck_cnt + 1'b1;
         end
      end
   end

   // Slot counter starts at its last value so the very first fall event is a frame start.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_slot <= SLOT_LAST;
         r_lrck <= 1'b1;
      end else if (w_fall) begin
         r_slot <= w_slot_nxt;
         if (w_slot_wrap) r_lrck <= ~r_lrck;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_data  <= 1'b0;
         r_tx_sh <= '0;
      end else if (w_fall) begin
         if (w_slot_wrap) begin
            r_data  <= 1'b0;
            r_tx_sh <= r_lrck ? w_frame_l_nxt : r_frame_r;
         end else if (w_bit_active) begin
            r_data  <= r_tx_sh[DATA_WIDTH-1];
            r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
         end else begin
            r_data <= 1'b0;
         end
      end
   end

   // Accept requires an empty holding register, so it never collides with a transfer.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_hold_full <= 1'b0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
         r_frame_l   <= '0;
         r_frame_r   <= '0;
         r_underrun  <= 1'b0;
      end else begin
         r_underrun <= w_frame_start & ~r_hold_full;
         if (w_frame_start && r_hold_full) begin
            r_frame_l   <= r_hold_l;
            r_frame_r   <= r_hold_r;
            r_hold_full <= 1'b0;
         end else if (w_accept) begin
            r_hold_l    <= iSL;
            r_hold_r    <= iSR;
            r_hold_full <= 1'b1;
         end
      end
   end

   assign oREADY       = ~r_hold_full;
   assign oUNDERRUN    = r_underrun;
   assign oAUD_XCK     = r_xck;
   assign oAUD_BCK     = r_bck;
   assign oAUD_LRCK    = r_lrck;
   assign oAUD_ADCLRCK = r_lrck;
   assign oAUD_DATA    = r_data;

`ifdef A_CODEC_ADC_EN
   localparam logic [8:0] TAPE_LO = 9'(128 - HYST);
   localparam logic [8:0] TAPE_HI = 9'(128 + HYST);

   logic                  r_rx_first;
   logic [DATA_WIDTH-1:0] r_rx_l;
   logic [DATA_WIDTH-1:0] r_rx_r;
   logic [DATA_WIDTH-1:0] r_adc_l;
   logic [DATA_WIDTH-1:0] r_adc_r;
   logic                  r_adc_valid;
   logic                  r_tape;

   logic                  w_rise;
   logic                  w_rx_bit;
   logic [7:0]            w_adc_top;
   logic [7:0]            w_tape_v;

   assign w_rise   = w_bck_wrap & ~r_bck;
   assign w_rx_bit = w_rise && (r_slot != '0) && (r_slot <= DW_S);

   if (DATA_WIDTH >= 8) begin : g_top_wide
      assign w_adc_top = r_adc_l[DATA_WIDTH-1 -: 8];
   end else begin : g_top_narrow
      assign w_adc_top = {r_adc_l, {(8-DATA_WIDTH){1'b0}}};
   end

   // Offset-binary view of the top byte: 128 is mid-scale.
   assign w_tape_v = {~w_adc_top[7], w_adc_top[6:0]};

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_rx_first  <= 1'b1;
         r_rx_l      <= '0;
         r_rx_r      <= '0;
         r_adc_l     <= '0;
         r_adc_r     <= '0;
         r_adc_valid <= 1'b0;
         r_tape      <= 1'b0;
      end else begin
         r_adc_valid <= 1'b0;
         if (w_rx_bit) begin
            if (r_lrck) r_rx_r <= {r_rx_r[DATA_WIDTH-2:0], iAUD_ADCDAT};
            else        r_rx_l <= {r_rx_l[DATA_WIDTH-2:0], iAUD_ADCDAT};
         end
         if (w_frame_start) begin
            r_rx_first <= 1'b0;
            if (!r_rx_first) begin
               r_adc_l     <= r_rx_l;
               r_adc_r     <= r_rx_r;
               r_adc_valid <= 1'b1;
            end
         end
         if (r_adc_valid) begin
            if ({1'b0, w_tape_v} < TAPE_LO)      r_tape <= 1'b1;
            else if ({1'b0, w_tape_v} > TAPE_HI) r_tape <= 1'b0;
         end
      end
   end

   assign oADC_L     = r_adc_l;
   assign oADC_R     = r_adc_r;
   assign oADC_VALID = r_adc_valid;
   assign oTAPE      = r_tape;
`else
   logic w_unused_adcdat;
   assign w_unused_adcdat = iAUD_ADCDAT;
   assign oADC_L          = '0;
   assign oADC_R          = '0;
   assign oADC_VALID      = 1'b0;
   assign oTAPE           = 1'b0;
`endif

endmodule

// File: tb/tb_a_codec_i2s.sv
// Self-checking bench for a_codec_i2s (default parameters). A monitor pops expected frames
// from a scoreboard at each frame start and checks every BCK fall event.
module tb_a_codec_i2s;

   logic        iCLK;
   logic        iRST;
   logic [15:0] iSL;
   logic [15:0] iSR;
   logic        iVALID;
   logic        oREADY;
   logic        oUNDERRUN;
   logic        oAUD_XCK;
   logic        oAUD_BCK;
   logic        oAUD_LRCK;
   logic        oAUD_DATA;
   logic        oAUD_ADCLRCK;
   logic        w_adcdat;
   logic [15:0] oADC_L;
   logic [15:0] oADC_R;
   logic        oADC_VALID;
   logic        oTAPE;

   assign w_adcdat = oAUD_DATA;

   a_codec_i2s dut (
      .iCLK(iCLK), .iRST(iRST), .iSL(iSL), .iSR(iSR), .iVALID(iVALID),
      .oREADY(oREADY), .oUNDERRUN(oUNDERRUN), .oAUD_XCK(oAUD_XCK), .oAUD_BCK(oAUD_BCK),
      .oAUD_LRCK(oAUD_LRCK), .oAUD_DATA(oAUD_DATA), .oAUD_ADCLRCK(oAUD_ADCLRCK),
      .iAUD_ADCDAT(w_adcdat), .oADC_L(oADC_L), .oADC_R(oADC_R),
      .oADC_VALID(oADC_VALID), .oTAPE(oTAPE)
   );

   localparam int FRAME = 288;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          acc;
   } ent_t;

   ent_t        sb[$];
   int          checks;
   int          failures;
   int          cyc;
   int          fcnt;
   bit          mon_en;
   bit          prev_bck;
   bit          first_fs;
   logic [15:0] cur_l;
   logic [15:0] cur_r;
   logic        exp_tape;

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   always @(posedge iCLK or posedge iRST) begin
      if (iRST) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Monitor: checks timing, LRCK, data bits, underrun and (if built) ADC outputs at every fall event.
   initial begin
      int          slot;
      int          k;
      bit          exp_ur;
      logic [15:0] ch;
      logic        exp_bit;
      logic [7:0]  v;
      ent_t        e;
      forever begin
         @(posedge iCLK);
         #1;
         if (mon_en && !iRST) begin
            if (prev_bck && !oAUD_BCK) begin
               slot = fcnt % 36;
               k    = slot % 18;
               checks++;
               if (cyc !== 8 + 8 * fcnt) begin
                  failures++;
                  $display("FAIL fall_timing: fall %0d at cycle %0d, want %0d", fcnt, cyc, 8 + 8 * fcnt);
               end
               checks++;
               if (oAUD_TAPE_OK() !== 1'b1) begin
                  failures++;
                  $display("FAIL tape: got %b want %b at fall %0d", oTAPE, exp_tape, fcnt);
               end
`ifdef A_CODEC_ADC_EN
               checks++;
               if (oADC_VALID !== (slot == 0 && !first_fs)) begin
                  failures++;
                  $display("FAIL adc_valid: got %b at fall %0d slot %0d", oADC_VALID, fcnt, slot);
               end
               if (slot == 0 && !first_fs) begin
                  checks++;
                  if (oADC_L !== cur_l || oADC_R !== cur_r) begin
                     failures++;
                     $display("FAIL adc_pair: got %h/%h want %h/%h", oADC_L, oADC_R, cur_l, cur_r);
                  end
                  v = {~cur_l[15], cur_l[14:8]};
                  if (v < 8'd125)      exp_tape = 1'b1;
                  else if (v > 8'd131) exp_tape = 1'b0;
               end
`else
               checks++;
               if ({oADC_L, oADC_R, oADC_VALID, oTAPE} !== 34'd0) begin
                  failures++;
                  $display("FAIL adc_tieoff: got %h %h %b %b want zeros", oADC_L, oADC_R, oADC_VALID, oTAPE);
               end
`endif
               if (slot == 0) begin
                  first_fs = 1'b0;
                  exp_ur   = 1'b1;
                  if (sb.size() > 0 && sb[0].acc < cyc) begin
                     e      = sb.pop_front();
                     cur_l  = e.l;
                     cur_r  = e.r;
                     exp_ur = 1'b0;
                     checks++;
                     if (oREADY !== 1'b1) begin
                        failures++;
                        $display("FAIL ready_after_fs: got %b want 1", oREADY);
                     end
                  end
               end else begin
                  exp_ur = 1'b0;
               end
               checks++;
               if (oUNDERRUN !== exp_ur) begin
                  failures++;
                  $display("FAIL underrun: got %b want %b at fall %0d", oUNDERRUN, exp_ur, fcnt);
               end
               ch      = (slot < 18) ? cur_l : cur_r;
               exp_bit = (k >= 1 && k <= 16) ? ch[16-k] : 1'b0;
               checks++;
               if (oAUD_LRCK !== (slot >= 18) || oAUD_ADCLRCK !== (slot >= 18) || oAUD_XCK !== 1'b0) begin
                  failures++;
                  $display("FAIL clocks: lrck %b adclrck %b xck %b at slot %0d", oAUD_LRCK, oAUD_ADCLRCK, oAUD_XCK, slot);
               end
               checks++;
               if (oAUD_DATA !== exp_bit) begin
                  failures++;
                  $display("FAIL data: got %b want %b at fall %0d slot %0d", oAUD_DATA, exp_bit, fcnt, slot);
               end
               fcnt++;
            end
            prev_bck = oAUD_BCK;
         end
      end
   end

   function automatic logic oAUD_TAPE_OK();
      return (oTAPE === exp_tape);
   endfunction

   task automatic do_reset();
      mon_en = 1'b0;
      @(negedge iCLK);
      iRST   = 1'b1;
      iVALID = 1'b0;
      sb.delete();
      fcnt     = 0;
      prev_bck = 1'b0;
      first_fs = 1'b1;
      cur_l    = '0;
      cur_r    = '0;
      exp_tape = 1'b0;
      repeat (3) @(negedge iCLK);
      iRST   = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      int n;
      @(negedge iCLK);
      iSL    = l;
      iSR    = r;
      iVALID = 1'b1;
      n      = 0;
      while (!oREADY && n < 1000) begin
         @(negedge iCLK);
         n++;
      end
      if (!oREADY) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: oREADY %b after %0d cycles, want 1", oREADY, n);
         iVALID = 1'b0;
         return;
      end
      @(posedge iCLK);
      #1;
      sb.push_back('{l, r, cyc});
      checks++;
      if (oREADY !== 1'b0) begin
         failures++;
         $display("FAIL ready_drop: got %b want 0", oREADY);
      end
      @(negedge iCLK);
      iVALID = 1'b0;
   endtask

   task automatic test_reset();
      iRST = 1'b1;
      repeat (2) @(negedge iCLK);
      checks++;
      if ({oAUD_XCK, oAUD_BCK, oAUD_LRCK, oAUD_DATA, oREADY, oUNDERRUN, oAUD_ADCLRCK} !== 7'b0010101) begin
         failures++;
         $display("FAIL reset_pins: got %b want 0010101",
                  {oAUD_XCK, oAUD_BCK, oAUD_LRCK, oAUD_DATA, oREADY, oUNDERRUN, oAUD_ADCLRCK});
      end
      checks++;
      if ({oADC_L, oADC_R, oADC_VALID, oTAPE} !== 34'd0) begin
         failures++;
         $display("FAIL reset_adc: got %h %h %b %b want zeros", oADC_L, oADC_R, oADC_VALID, oTAPE);
      end
      do_reset();
   endtask

   task automatic test_idle();
      repeat (2 * FRAME + 16) @(posedge iCLK);
   endtask

   task automatic test_basic_frame();
      send(16'hA5C3, 16'h0001);
      repeat (2 * FRAME + 16) @(posedge iCLK);
   endtask

   task automatic test_valid_on_frame_start();
      int fs;
      int n;
      fs = 8 + FRAME * ((cyc - 8) / FRAME + 2);
      n  = 0;
      @(negedge iCLK);
      while (cyc != fs - 1 && n < 1000) begin
         @(negedge iCLK);
         n++;
      end
      checks++;
      if (cyc != fs - 1 || oREADY !== 1'b1) begin
         failures++;
         $display("FAIL vfs_setup: cycle %0d ready %b, want cycle %0d ready 1", cyc, oREADY, fs - 1);
      end
      iSL    = 16'h1234;
      iSR    = 16'hFEDC;
      iVALID = 1'b1;
      @(posedge iCLK);
      #1;
      sb.push_back('{16'h1234, 16'hFEDC, cyc});
      checks++;
      if (oUNDERRUN !== 1'b1 || oREADY !== 1'b0) begin
         failures++;
         $display("FAIL vfs_underrun: underrun %b ready %b, want 1 0", oUNDERRUN, oREADY);
      end
      @(negedge iCLK);
      iVALID = 1'b0;
      repeat (2 * FRAME + 16) @(posedge iCLK);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         send(16'($urandom), 16'($urandom));
      end
      repeat (2 * FRAME) @(posedge iCLK);
   endtask

   task automatic test_tape();
      send(16'h8000, 16'h1111);
      send(16'h7FFF, 16'h2222);
      send(16'h0100, 16'h3333);
      repeat (3 * FRAME) @(posedge iCLK);
   endtask

   task automatic test_reset_mid();
      int fs;
      int n;
      send(16'hBEEF, 16'hCAFE);
      fs = 8 + FRAME * ((cyc - 8) / FRAME + 1);
      n  = 0;
      @(negedge iCLK);
      while (cyc != fs + FRAME / 2 + 50 && n < 1000) begin
         @(negedge iCLK);
         n++;
      end
      mon_en = 1'b0;
      iRST   = 1'b1;
      #1;
      checks++;
      if ({oAUD_XCK, oAUD_BCK, oAUD_LRCK, oAUD_DATA, oREADY, oUNDERRUN, oAUD_ADCLRCK} !== 7'b0010101) begin
         failures++;
         $display("FAIL midreset_pins: got %b want 0010101",
                  {oAUD_XCK, oAUD_BCK, oAUD_LRCK, oAUD_DATA, oREADY, oUNDERRUN, oAUD_ADCLRCK});
      end
      checks++;
      if ({oADC_L, oADC_R, oADC_VALID, oTAPE} !== 34'd0) begin
         failures++;
         $display("FAIL midreset_adc: got %h %h %b %b want zeros", oADC_L, oADC_R, oADC_VALID, oTAPE);
      end
      do_reset();
      test_idle();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mon_en   = 1'b0;
      prev_bck = 1'b0;
      first_fs = 1'b1;
      cur_l    = '0;
      cur_r    = '0;
      exp_tape = 1'b0;
      fcnt     = 0;
      iRST     = 1'b1;
      iVALID   = 1'b0;
      iSL      = '0;
      iSR      = '0;
      test_reset();
      test_idle();
      test_basic_frame();
      test_valid_on_frame_start();
      test_back_to_back();
      test_tape();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
